// File: rtl/ex_mem_ccreg.sv
// Execute-stage back end: condition-code register, jXX/cmovXX condition
// evaluation, cmov destination squash and the E/M pipeline register.
module ex_mem_ccreg #(
    parameter int         N     = 64,
    parameter logic [3:0] RNONE = 4'hF,
    parameter logic [3:0] I_NOP = 4'h1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         e_valid,
    input  logic [3:0]   e_icode,
    input  logic [3:0]   e_ifun,
    input  logic [N-1:0] e_valE,
    input  logic [N-1:0] e_valA,
    input  logic [3:0]   e_dstE,
    input  logic [3:0]   e_dstM,
    input  logic [2:0]   alu_cf,
    input  logic         exc_block,
    input  logic         m_stall,
    input  logic         m_bubble,
    output logic [2:0]   cc,
    output logic         e_cnd,
    output logic [3:0]   e_dstE_out,
    output logic         M_valid,
    output logic [3:0]   M_icode,
    output logic         M_cnd,
    output logic [N-1:0] M_valE,
    output logic [N-1:0] M_valA,
    output logic [3:0]   M_dstE,
    output logic [3:0]   M_dstM
);

    localparam logic [3:0] I_CMOV = 4'h2;
    localparam logic [3:0] I_OPQ  = 4'h6;

    logic [2:0] cc_q;
    logic       set_cc;
    logic       f_of;
    logic       f_zf;
    logic       f_sf;
    logic       lt;

    assign cc     = cc_q;
    assign f_of   = cc_q[0];
    assign f_zf   = cc_q[1];
    assign f_sf   = cc_q[2];
    assign lt     = f_sf ^ f_of;

    // A stalled OPq will be re-presented later; updating now would double-apply it.
    assign set_cc = e_valid & (e_icode == I_OPQ) & ~exc_block & ~m_stall;

    always_comb begin
        e_cnd = 1'b0;
        case (e_ifun)
            4'h0:    e_cnd = 1'b1;
            4'h1:    e_cnd = lt | f_zf;
            4'h2:    e_cnd = lt;
            4'h3:    e_cnd = f_zf;
            4'h4:    e_cnd = ~f_zf;
            4'h5:    e_cnd = ~lt;
            4'h6:    e_cnd = ~lt & ~f_zf;
            default: e_cnd = 1'b0;
        endcase
    end

    assign e_dstE_out = ((e_icode == I_CMOV) && !e_cnd) ? RNONE : e_dstE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_q <= 3'b010;
        end else if (set_cc) begin
            cc_q <= alu_cf;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            M_valid <= 1'b0;
            M_icode <= I_NOP;
            M_cnd   <= 1'b0;
            M_valE  <= '0;
            M_valA  <= '0;
            M_dstE  <= RNONE;
            M_dstM  <= RNONE;
        end else if (m_bubble) begin
            M_valid <= 1'b0;
            M_icode <= I_NOP;
            M_cnd   <= 1'b0;
            M_valE  <= '0;
            M_valA  <= '0;
            M_dstE  <= RNONE;
            M_dstM  <= RNONE;
        end else if (!m_stall) begin
            M_valid <= e_valid;
            M_icode <= e_icode;
            M_cnd   <= e_cnd;
            M_valE  <= e_valE;
            M_valA  <= e_valA;
            M_dstE  <= e_dstE_out;
            M_dstM  <= e_dstM;
        end
    end

endmodule

// File: tb/tb_ex_mem_ccreg.sv
// Self-checking bench for ex_mem_ccreg: directed scenarios plus randomized
// traffic against a flag-level reference model.
module tb_ex_mem_ccreg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        e_valid = 1'b0;
    logic [3:0]  e_icode = 4'h0;
    logic [3:0]  e_ifun = 4'h0;
    logic [63:0] e_valE = '0;
    logic [63:0] e_valA = '0;
    logic [3:0]  e_dstE = 4'h0;
    logic [3:0]  e_dstM = 4'h0;
    logic [2:0]  alu_cf = 3'b000;
    logic        exc_block = 1'b0;
    logic        m_stall = 1'b0;
    logic        m_bubble = 1'b0;
    logic [2:0]  cc;
    logic        e_cnd;
    logic [3:0]  e_dstE_out;
    logic        M_valid;
    logic [3:0]  M_icode;
    logic        M_cnd;
    logic [63:0] M_valE;
    logic [63:0] M_valA;
    logic [3:0]  M_dstE;
    logic [3:0]  M_dstM;

    int tests = 0;
    int failed = 0;

    // reference model state: individual flags and E/M fields
    bit          r_zf, r_sf, r_of;
    bit          r_valid, r_cnd;
    logic [3:0]  r_icode, r_dstE, r_dstM;
    logic [63:0] r_valE, r_valA;

    ex_mem_ccreg dut (
        .clk(clk), .rst_n(rst_n), .e_valid(e_valid), .e_icode(e_icode),
        .e_ifun(e_ifun), .e_valE(e_valE), .e_valA(e_valA), .e_dstE(e_dstE),
        .e_dstM(e_dstM), .alu_cf(alu_cf), .exc_block(exc_block),
        .m_stall(m_stall), .m_bubble(m_bubble), .cc(cc), .e_cnd(e_cnd),
        .e_dstE_out(e_dstE_out), .M_valid(M_valid), .M_icode(M_icode),
        .M_cnd(M_cnd), .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE),
        .M_dstM(M_dstM)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_cond(input int ifun, input bit zf, input bit sf, input bit of);
        bit less;
        less = (sf != of);
        case (ifun)
            0: return 1'b1;
            1: return less || zf;
            2: return less;
            3: return zf;
            4: return !zf;
            5: return !less;
            6: return !less && !zf;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] ref_dst();
        if (e_icode == 4'h2 && !ref_cond(int'(e_ifun), r_zf, r_sf, r_of)) return 4'hF;
        return e_dstE;
    endfunction

    task automatic ref_reset();
        r_zf = 1; r_sf = 0; r_of = 0;
        r_valid = 0; r_icode = 4'h1; r_cnd = 0;
        r_valE = '0; r_valA = '0; r_dstE = 4'hF; r_dstM = 4'hF;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".cc"}, {61'd0, cc}, {61'd0, r_sf, r_zf, r_of});
        chk({tag, ".M_valid"}, {63'd0, M_valid}, {63'd0, r_valid});
        chk({tag, ".M_icode"}, {60'd0, M_icode}, {60'd0, r_icode});
        chk({tag, ".M_cnd"}, {63'd0, M_cnd}, {63'd0, r_cnd});
        chk({tag, ".M_valE"}, M_valE, r_valE);
        chk({tag, ".M_valA"}, M_valA, r_valA);
        chk({tag, ".M_dstE"}, {60'd0, M_dstE}, {60'd0, r_dstE});
        chk({tag, ".M_dstM"}, {60'd0, M_dstM}, {60'd0, r_dstM});
    endtask

    task automatic drive(input bit v, input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] ve, input logic [3:0] de, input logic [2:0] cf,
                         input bit ex, input bit st, input bit bb);
        e_valid = v; e_icode = ic; e_ifun = fn; e_valE = ve; e_valA = ~ve;
        e_dstE = de; e_dstM = de ^ 4'h5; alu_cf = cf;
        exc_block = ex; m_stall = st; m_bubble = bb;
    endtask

    // Called just after a falling edge with inputs set; runs one rising edge.
    task automatic cycle(input string tag);
        bit          exp_cnd;
        logic [3:0]  exp_dst;
        #1;
        exp_cnd = ref_cond(int'(e_ifun), r_zf, r_sf, r_of);
        exp_dst = ref_dst();
        chk({tag, ".e_cnd"}, {63'd0, e_cnd}, {63'd0, exp_cnd});
        chk({tag, ".e_dstE_out"}, {60'd0, e_dstE_out}, {60'd0, exp_dst});
        @(posedge clk);
        if (m_bubble) begin
            r_valid = 0; r_icode = 4'h1; r_cnd = 0;
            r_valE = '0; r_valA = '0; r_dstE = 4'hF; r_dstM = 4'hF;
        end else if (!m_stall) begin
            r_valid = e_valid; r_icode = e_icode; r_cnd = exp_cnd;
            r_valE = e_valE; r_valA = e_valA; r_dstE = exp_dst; r_dstM = e_dstM;
        end
        if (e_valid && e_icode == 4'h6 && !exc_block && !m_stall) begin
            r_of = alu_cf[0]; r_zf = alu_cf[1]; r_sf = alu_cf[2];
        end
        #1;
        check_state(tag);
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] icodes [8];
        icodes = '{4'h2, 4'h6, 4'h7, 4'h2, 4'h6, 4'h7, 4'h0, 4'h5};
        ref_reset();

        // reset held with random inputs and a running clock
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1'b1, 4'h6, 4'($urandom), {$urandom, $urandom}, 4'($urandom),
                  3'($urandom), 1'b0, 1'b0, 1'b0);
        end
        e_icode = 4'h7; e_ifun = 4'h3;
        #1;
        check_state("reset");
        chk("reset.cc_const", {61'd0, cc}, 64'h2);
        chk("reset.e_cnd_je", {63'd0, e_cnd}, 64'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // OPq setting ZF, then jle
        drive(1'b1, 4'h6, 4'h0, 64'h0, 4'h1, 3'b010, 1'b0, 1'b0, 1'b0);
        cycle("opq");
        chk("opq.cc_const", {61'd0, cc}, 64'h2);
        drive(1'b1, 4'h7, 4'h1, 64'h40, 4'hF, 3'b000, 1'b0, 1'b0, 1'b0);
        cycle("jle");
        chk("jle.M_cnd_const", {63'd0, M_cnd}, 64'h1);

        // untaken then taken cmovg
        drive(1'b1, 4'h6, 4'h1, 64'h9, 4'h2, 3'b100, 1'b0, 1'b0, 1'b0);
        cycle("opq_sf");
        drive(1'b1, 4'h2, 4'h6, 64'h77, 4'h3, 3'b000, 1'b0, 1'b0, 1'b0);
        cycle("cmovg_untaken");
        chk("cmovg_untaken.M_dstE_const", {60'd0, M_dstE}, 64'hF);
        drive(1'b1, 4'h6, 4'h1, 64'h9, 4'h2, 3'b000, 1'b0, 1'b0, 1'b0);
        cycle("opq_clear");
        drive(1'b1, 4'h2, 4'h6, 64'h78, 4'h3, 3'b000, 1'b0, 1'b0, 1'b0);
        cycle("cmovg_taken");
        chk("cmovg_taken.M_dstE_const", {60'd0, M_dstE}, 64'h3);

        // exception blocks the CC update
        drive(1'b1, 4'h6, 4'h0, 64'h5, 4'h4, 3'b101, 1'b1, 1'b0, 1'b0);
        cycle("exc_block");
        chk("exc_block.cc_const", {61'd0, cc}, 64'h0);
        drive(1'b1, 4'h6, 4'h0, 64'h5, 4'h4, 3'b101, 1'b0, 1'b0, 1'b0);
        cycle("exc_clear");
        chk("exc_clear.cc_const", {61'd0, cc}, 64'h5);

        // stall holds E/M and blocks OPq flags; bubble beats stall
        drive(1'b1, 4'h3, 4'h0, 64'h1234, 4'h6, 3'b000, 1'b0, 1'b0, 1'b0);
        cycle("load");
        drive(1'b1, 4'h6, 4'h0, 64'hAAAA, 4'h7, 3'b010, 1'b0, 1'b1, 1'b0);
        cycle("stall1");
        drive(1'b1, 4'h6, 4'h0, 64'hBBBB, 4'h8, 3'b110, 1'b0, 1'b1, 1'b0);
        cycle("stall2");
        chk("stall.M_valE_const", M_valE, 64'h1234);
        chk("stall.cc_const", {61'd0, cc}, 64'h5);
        drive(1'b1, 4'h6, 4'h0, 64'hCCCC, 4'h9, 3'b010, 1'b0, 1'b1, 1'b1);
        cycle("stall_bubble");
        chk("stall_bubble.M_icode_const", {60'd0, M_icode}, 64'h1);
        drive(1'b0, 4'h7, 4'h0, 64'hDDDD, 4'h2, 3'b000, 1'b0, 1'b0, 1'b0);
        cycle("invalid");

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 7) != 0), icodes[$urandom_range(0, 7)],
                  4'($urandom_range(0, 8)), {$urandom, $urandom}, 4'($urandom),
                  3'($urandom), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
            cycle("rand");
        end

        // async reset between edges
        drive(1'b1, 4'h6, 4'h0, 64'h55, 4'h1, 3'b001, 1'b0, 1'b0, 1'b0);
        cycle("pre_reset");
        #2;
        rst_n = 1'b0;
        ref_reset();
        #1;
        check_state("async_reset");
        chk("async_reset.cc_const", {61'd0, cc}, 64'h2);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 4'h2, 4'h4, 64'h66, 4'h3, 3'b000, 1'b0, 1'b0, 1'b0);
        cycle("post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
